// File: rtl/ttl_74299.sv
// 74299-style universal shift/storage register with a shared 3-state parallel bus.
// Latency: one Clk edge from mode/data to register; outputs combinational from register.
// Backpressure: none; the bus is released whenever either OE is high or mode is parallel load.
module ttl_74299 #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             S0,
    input  logic             S1,
    input  logic             OE1_bar,
    input  logic             OE2_bar,
    input  logic             DSR,
    input  logic             DSL,
    inout  wire  [WIDTH-1:0] IO,
    output logic             Q0,
    output logic             Q_last
);

    // Zero-delay model: rise/fall timing belongs to back-annotated netlists.
    if (WIDTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
        $error("ttl_74299: WIDTH must be >= 2 and delays non-negative");
    end

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] shift_q;
    logic [1:0]       mode;
    logic             io_drive;

    assign mode = {S1, S0};

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            shift_q <= '0;
        end else begin
            case (mode)
                MODE_SHR:  shift_q <= {shift_q[WIDTH-2:0], DSR};
                MODE_SHL:  shift_q <= {DSL, shift_q[WIDTH-1:1]};
                MODE_LOAD: shift_q <= IO;
                default:   shift_q <= shift_q;
            endcase
        end
    end

    // Load mode always releases the bus so an external driver never contends.
    assign io_drive = ~OE1_bar & ~OE2_bar & ~(S1 & S0);
    assign IO       = io_drive ? shift_q : {WIDTH{1'bz}};

    assign Q0     = shift_q[0];
    assign Q_last = shift_q[WIDTH-1];

endmodule
